// File: rtl/dtc_therm_decoder.sv
// rtl/dtc_therm_decoder.sv - thermometer class-code decoder with per-class hit counters
//
// Purpose: decodes a 7-bit thermometer class code into a class index 0..7, flags
// bubble (illegal) codes, and keeps one saturating hit counter per class plus a
// saturating bubble counter. Counters are readable through a registered read port.
//
// Optional feature macro: DTC_BUBBLE_CORRECT_EN
//   defined   : bubble codes decode to popcount(in_code)
//   undefined : bubble codes decode to the length of the run of ones from bit 0
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_code  input handshake and thermometer code
//   out_valid/out_ready        output handshake
//   out_class/out_err          decoded class index and bubble flag
//   clr                        synchronous clear of all counters
//   rd_en/rd_addr              counter read request and class select
//   rd_data/rd_valid           registered read result and its strobe
//   err_cnt                    running bubble-code count
module dtc_therm_decoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_class,
  output logic               out_err,
  input  logic               clr,
  input  logic               rd_en,
  input  logic [2:0]         rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [COUNT_W-1:0] err_cnt
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // Release flag: goes high on the first edge after rst_n rises, so the edge
  // coincident with (or racing) the release never performs an accept.
  logic rst_done_q;

  logic               out_valid_q, out_valid_d;
  logic [2:0]         out_class_q, out_class_d;
  logic               out_err_q,   out_err_d;
  logic [COUNT_W-1:0] cnt_q [8];
  logic [COUNT_W-1:0] cnt_d [8];
  logic [COUNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [COUNT_W-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic       accept;
  logic       legal;
  logic [2:0] run_len;
  logic [2:0] pop_cnt;
  logic [2:0] dec_class;
  logic       run_open;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && rst_done_q;

  // Code analysis: legality, leading run of ones from bit 0, and popcount.
  always_comb begin
    legal    = 1'b0;
    run_len  = 3'd0;
    pop_cnt  = 3'd0;
    run_open = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (in_code == ((7'd1 << k) - 7'd1)) legal = 1'b1;
    end
    for (int i = 0; i < 7; i++) begin
      if (run_open && in_code[i]) run_len = run_len + 3'd1;
      else                        run_open = 1'b0;
      pop_cnt = pop_cnt + {2'b00, in_code[i]};
    end
    // For legal codes both measures equal k; they only differ on bubbles.
`ifdef DTC_BUBBLE_CORRECT_EN
    dec_class = pop_cnt;
`else
    dec_class = run_len;
`endif
  end

  // Output register: load on accept, drop valid only when drained with no refill.
  always_comb begin
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_class_d = dec_class;
      out_err_d   = !legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Counters: clr overrides a concurrent accept, which then goes uncounted.
  always_comb begin
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      for (int i = 0; i < 8; i++) cnt_d[i] = '0;
      err_cnt_d = '0;
    end else if (accept) begin
      if (cnt_q[dec_class] != CNT_MAX) cnt_d[dec_class] = cnt_q[dec_class] + 1'b1;
      if (!legal && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Read port samples the current register value, so a colliding update is
  // not yet visible to the read.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) rd_data_d = cnt_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= 3'd0;
      out_err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      err_cnt_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rst_done_q  <= 1'b1;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_err   = out_err_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dtc_therm_decoder.sv
// tb/tb_dtc_therm_decoder.sv - self-checking bench for dtc_therm_decoder
module tb_dtc_therm_decoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_code;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_class;
  logic          out_err;
  logic          clr;
  logic          rd_en;
  logic [2:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          rd_valid;
  logic [CW-1:0] err_cnt;

  dtc_therm_decoder #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] code;
    logic [2:0] cls_run;
    logic [2:0] cls_pop;
    logic       err;
  } vec_t;

  vec_t vecs[13];
  int   exp_cnt[8];
  int   exp_err;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sel_class(input vec_t v);
`ifdef DTC_BUBBLE_CORRECT_EN
    return int'(v.cls_pop);
`else
    return int'(v.cls_run);
`endif
  endfunction

  task automatic read_cnt(input int addr, input int exp, input string name);
    rd_en   = 1'b1;
    rd_addr = 3'(addr);
    step();
    rd_en   = 1'b0;
    check({name, "_rd_valid"}, int'(rd_valid), 1);
    check(name, int'(rd_data), exp);
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < 8; i++) read_cnt(i, exp_cnt[i], $sformatf("%s_cnt%0d", name, i));
    check({name, "_err_cnt"}, int'(err_cnt), exp_err);
  endtask

  initial begin
    vec_t v;
    int   old0;
    vecs[0]  = '{7'b0000000, 3'd0, 3'd0, 1'b0};
    vecs[1]  = '{7'b0000001, 3'd1, 3'd1, 1'b0};
    vecs[2]  = '{7'b0000011, 3'd2, 3'd2, 1'b0};
    vecs[3]  = '{7'b0000111, 3'd3, 3'd3, 1'b0};
    vecs[4]  = '{7'b0001111, 3'd4, 3'd4, 1'b0};
    vecs[5]  = '{7'b0011111, 3'd5, 3'd5, 1'b0};
    vecs[6]  = '{7'b0111111, 3'd6, 3'd6, 1'b0};
    vecs[7]  = '{7'b1111111, 3'd7, 3'd7, 1'b0};
    vecs[8]  = '{7'b0010111, 3'd3, 3'd4, 1'b1};
    vecs[9]  = '{7'b0000010, 3'd0, 3'd1, 1'b1};
    vecs[10] = '{7'b1111110, 3'd0, 3'd6, 1'b1};
    vecs[11] = '{7'b1011111, 3'd5, 3'd6, 1'b1};
    vecs[12] = '{7'b1000000, 3'd0, 3'd1, 1'b1};
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
    exp_err = 0;

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
    clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_in_ready", int'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    step();

    // Single legal accept, then read its counter.
    in_valid = 1'b1; in_code = 7'b0001111;
    step();
    in_valid = 1'b0;
    check("first_out_valid", int'(out_valid), 1);
    check("first_out_class", int'(out_class), 4);
    check("first_out_err", int'(out_err), 0);
    exp_cnt[4]++;
    read_cnt(4, 1, "first_rd4");
    step();
    check("rd_valid_pulse", int'(rd_valid), 0);

    // Table vectors at full rate.
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      in_valid = 1'b1; in_code = v.code;
      step();
      check($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      check($sformatf("vec%0d_class", i), int'(out_class), sel_class(v));
      check($sformatf("vec%0d_err", i), int'(out_err), int'(v.err));
      exp_cnt[sel_class(v)]++;
      if (v.err) exp_err++;
    end
    in_valid = 1'b0;
    read_all("table");

    // Backpressure hold.
    out_ready = 1'b0; in_valid = 1'b1; in_code = 7'b0000111;
    step();
    exp_cnt[3]++;
    in_code = 7'b0011111;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_in_ready", i), int'(in_ready), 0);
      check($sformatf("hold%0d_valid", i), int'(out_valid), 1);
      check($sformatf("hold%0d_class", i), int'(out_class), 3);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", int'(in_ready), 1);
    step();
    exp_cnt[5]++;
    check("release_class", int'(out_class), 5);
    in_valid = 1'b0;
    step();
    check("drain_valid", int'(out_valid), 0);
    read_all("hold");

    // clr concurrent with accept and read of class 0.
    old0 = exp_cnt[0];
    clr = 1'b1; in_valid = 1'b1; in_code = 7'b0000000; rd_en = 1'b1; rd_addr = 3'd0;
    step();
    clr = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    check("clr_out_valid", int'(out_valid), 1);
    check("clr_out_class", int'(out_class), 0);
    check("clr_rd_valid", int'(rd_valid), 1);
    check("clr_rd_old", int'(rd_data), old0);
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
    exp_err = 0;
    read_all("clr");

    // Saturation with a 4-bit counter.
    in_valid = 1'b1; in_code = 7'b1111111;
    for (int i = 0; i < 20; i++) step();
    in_valid = 1'b0;
    exp_cnt[7] = 15;
    read_all("sat");

    // Single bubble after clear.
    in_valid = 1'b1; in_code = 7'b0010111;
    step();
    in_valid = 1'b0;
    check("bub_err", int'(out_err), 1);
    check("bub_err_cnt", int'(err_cnt), 1);
    check("bub_class", int'(out_class), sel_class(vecs[8]));

    // Reset while an output is held.
    out_ready = 1'b0; in_valid = 1'b1; in_code = 7'b0000011;
    step();
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_class", int'(out_class), 0);
    check("async_rst_err_cnt", int'(err_cnt), 0);
    check("async_rst_rd_data", int'(rd_data), 0);
    check("async_rst_in_ready", int'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
    exp_err = 0;
    read_all("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
